// File: rtl/alu_operand_loader_pkg.sv
// rtl/alu_operand_loader_pkg.sv - shared types and constants for the ALU operand loader
// Purpose: FSM state encoding, key index constants and opcode width used by
//          the loader top level and its ALU-side interface.
package alu_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } loader_state_t;

  localparam int KEY_LOAD  = 0;
  localparam int KEY_CLEAR = 1;
  localparam int KEY_BACK  = 2;

  localparam int OP_W = 4;

endpackage

// File: rtl/alu_operand_loader_if.sv
// rtl/alu_operand_loader_if.sv - ALU-side operand bundle driven by the loader
// Purpose: carries the registered operands, opcode and status to the ALU wrapper.
// Signals: portA/portB (DATA_W) operands, op (OP_W) opcode,
//          valid (all three loaded), state_o (FSM state for LEDs).
// Modports: master = loader (drives), slave = ALU wrapper (reads).
interface alu_operand_loader_if
  import alu_loader_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] portA;
  logic [DATA_W-1:0] portB;
  logic [OP_W-1:0]   op;
  logic              valid;
  logic [1:0]        state_o;

  modport master (
    output portA,
    output portB,
    output op,
    output valid,
    output state_o
  );

  modport slave (
    input portA,
    input portB,
    input op,
    input valid,
    input state_o
  );

endinterface

// File: rtl/alu_operand_loader_key_debounce.sv
// rtl/alu_operand_loader_key_debounce.sv - synchroniser, debouncer and press-pulse for one key
// Purpose: conditions one raw active-low push-button into a single-cycle press pulse.
// Ports: CLK clock, nRST sync active-low reset, key_n raw async key (low = pressed),
//        press registered one-cycle pulse on each debounced press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      stable_d <= stable;
      // Falling edge of the debounced level only; releases are ignored.
      press    <= stable_d & ~stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - stepwise operand/opcode entry FSM for the board ALU wrapper
// Purpose: loads operand A, operand B and the opcode from the switches on debounced
//          LOAD presses; BACK steps back one stage, CLEAR zeroes everything.
// Ports: CLK clock, nRST sync active-low reset, key_n[2:0] raw keys
//        ({BACK, CLEAR, LOAD}, active-low), sw[SW_W-1:0] raw switches,
//        alu master modport carrying portA, portB, op, valid, state_o.
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_W            = 17,
  parameter int DATA_W          = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [2:0]           key_n,
  input  logic [SW_W-1:0]      sw,
  alu_operand_loader_if.master alu
);

  logic [2:0]        press;
  loader_state_t     state;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [OP_W-1:0]   reg_op;
  logic              reg_valid;
  logic [DATA_W-1:0] sw_ext;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .CLK  (CLK),
      .nRST (nRST),
      .key_n(key_n[k]),
      .press(press[k])
    );
  end

  // Switches are quasi-static, so they are captured without synchronisers.
  assign sw_ext = DATA_W'($signed(sw));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= LOAD_A;
      reg_a     <= '0;
      reg_b     <= '0;
      reg_op    <= '0;
      reg_valid <= 1'b0;
    end else if (press[KEY_CLEAR]) begin
      state     <= LOAD_A;
      reg_a     <= '0;
      reg_b     <= '0;
      reg_op    <= '0;
      reg_valid <= 1'b0;
    end else if (press[KEY_BACK]) begin
      // No BACK destination is SHOW, so valid always drops.
      reg_valid <= 1'b0;
      case (state)
        SHOW:    state <= LOAD_OP;
        LOAD_OP: state <= LOAD_B;
        default: state <= LOAD_A;
      endcase
    end else if (press[KEY_LOAD]) begin
      case (state)
        LOAD_A: begin
          reg_a     <= sw_ext;
          state     <= LOAD_B;
          reg_valid <= 1'b0;
        end
        LOAD_B: begin
          reg_b     <= sw_ext;
          state     <= LOAD_OP;
          reg_valid <= 1'b0;
        end
        LOAD_OP: begin
          reg_op    <= sw[OP_W-1:0];
          state     <= SHOW;
          reg_valid <= 1'b1;
        end
        default: begin
          state     <= LOAD_A;
          reg_valid <= 1'b0;
        end
      endcase
    end
  end

  assign alu.portA   = reg_a;
  assign alu.portB   = reg_b;
  assign alu.op      = reg_op;
  assign alu.valid   = reg_valid;
  assign alu.state_o = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed self-checking bench for alu_operand_loader
module tb_alu_operand_loader;

  logic        CLK;
  logic        nRST;
  logic [2:0]  key_n;
  logic [16:0] sw;

  int pass_cnt  = 0;
  int check_cnt = 0;

  alu_operand_loader_if #(.DATA_W(32)) alu_bus ();

  alu_operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .SW_W           (17),
    .DATA_W         (32)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .key_n(key_n),
    .sw   (sw),
    .alu  (alu_bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Hold the masked keys low for 'hold' sampling edges, release, then let
  // the press propagate and the release debounce settle.
  task automatic press_keys(input logic [2:0] mask, input int hold);
    key_n = ~mask;
    tick(hold);
    key_n = 3'b111;
    tick(14);
  endtask

  task automatic check_all(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic v, input logic [1:0] st);
    check({tag, "_a"},  alu_bus.portA,   a);
    check({tag, "_b"},  alu_bus.portB,   b);
    check({tag, "_op"}, alu_bus.op,      op);
    check({tag, "_v"},  alu_bus.valid,   v);
    check({tag, "_st"}, alu_bus.state_o, st);
  endtask

  initial begin
    nRST  = 1'b0;
    key_n = 3'b111;
    sw    = '0;
    tick(2);
    check_all("reset", 32'h0, 32'h0, 4'h0, 1'b0, 2'd0);
    nRST = 1'b1;
    tick(2);

    // Exact press latency on operand A with a negative switch value.
    sw    = 17'h1FFFF;
    key_n = 3'b110;
    tick(7);
    check("lat_a_before", alu_bus.portA, 32'h0);
    tick(1);
    check("lat_a_after", alu_bus.portA, 32'hFFFFFFFF);
    check("lat_st", alu_bus.state_o, 2'd1);
    key_n = 3'b111;
    tick(14);

    sw = 17'h00005;
    press_keys(3'b001, 6);
    check_all("load_b", 32'hFFFFFFFF, 32'h5, 4'h0, 1'b0, 2'd2);

    sw = 17'h00002;
    press_keys(3'b001, 6);
    check_all("load_op", 32'hFFFFFFFF, 32'h5, 4'h2, 1'b1, 2'd3);

    // Bounce: two short low excursions must be rejected.
    key_n = 3'b110; tick(3);
    key_n = 3'b111; tick(2);
    key_n = 3'b110; tick(3);
    key_n = 3'b111; tick(14);
    check_all("bounce", 32'hFFFFFFFF, 32'h5, 4'h2, 1'b1, 2'd3);

    press_keys(3'b001, 6);
    check_all("one_step", 32'hFFFFFFFF, 32'h5, 4'h2, 1'b0, 2'd0);

    // CLEAR beats LOAD when both arrive together.
    sw = 17'h00005;
    press_keys(3'b001, 6);
    check("prio_pre_a", alu_bus.portA, 32'h5);
    check("prio_pre_st", alu_bus.state_o, 2'd1);
    press_keys(3'b011, 6);
    check_all("prio", 32'h0, 32'h0, 4'h0, 1'b0, 2'd0);

    // BACK from SHOW keeps the registers.
    sw = 17'h1; press_keys(3'b001, 6);
    sw = 17'h2; press_keys(3'b001, 6);
    sw = 17'h3; press_keys(3'b001, 6);
    check_all("show", 32'h1, 32'h2, 4'h3, 1'b1, 2'd3);
    press_keys(3'b100, 6);
    check_all("back", 32'h1, 32'h2, 4'h3, 1'b0, 2'd2);
    sw = 17'h7; press_keys(3'b001, 6);
    check_all("reload_op", 32'h1, 32'h2, 4'h7, 1'b1, 2'd3);

    // BACK in LOAD_A stays put.
    press_keys(3'b001, 6);
    press_keys(3'b100, 6);
    check_all("back_a", 32'h1, 32'h2, 4'h7, 1'b0, 2'd0);

    // Reset in the middle of a debounce discards the partial count.
    sw    = 17'h00009;
    key_n = 3'b110;
    tick(2);
    nRST = 1'b0;
    tick(1);
    nRST = 1'b1;
    tick(2);
    key_n = 3'b111;
    tick(14);
    check_all("mid_rst", 32'h0, 32'h0, 4'h0, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Operand-entry front end for the board-level ALU wrapper. Turns raw push-button and slide-switch activity into a clean, stepwise load of operand A, operand B and the opcode. Drives the ALU interface's `portA`, `portB` and `op` from registers. Replaces direct switch/key wiring so that operands stay stable while the user changes the switches.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); minimum 1.
- `SW_W`, default 17: switch bits used as the signed operand field.
- `DATA_W`, default 32: operand width.

Ports:
- `CLK`, input, 1: the single clock.
- `nRST`, input, 1: reset, synchronous and active-low.
- `key_n`, input, 3: raw push-buttons, active-low and asynchronous.
  - [0] = LOAD
  - [1] = CLEAR
  - [2] = BACK
- `sw`, input, SW_W: raw switches. Used as the operand field, and `sw[3:0]` as the opcode field.
- `portA`, output, DATA_W: registered operand A.
- `portB`, output, DATA_W: registered operand B.
- `op`, output, 4: registered ALU opcode.
- `valid`, output, 1: high while A, B and op are all loaded (SHOW state).
- `state_o`, output, 2: current FSM state encoding, for LEDs.

## Operation
Key conditioning, per key:
- 2-flop synchroniser, then a debouncer.
- Debounced level `stable` resets to 1 (released).
- Counter increments each cycle the synchronised level differs from `stable`, and clears on any cycle they match.
- When the counter equals DEBOUNCE_CYCLES-1 while still mismatched, `stable` takes the new level at the next edge and the counter clears.
- A registered one-cycle press pulse is produced on each 1→0 transition of `stable`. Releases produce no event.

FSM states, in encoding order 0..3: LOAD_A, LOAD_B, LOAD_OP, SHOW.
- LOAD pulse:
  - LOAD_A: `portA` ← sign-extend(`sw`), go to LOAD_B.
  - LOAD_B: `portB` ← sign-extend(`sw`), go to LOAD_OP.
  - LOAD_OP: `op` ← `sw[3:0]`, go to SHOW.
  - SHOW: go to LOAD_A; registers hold.
- BACK pulse: SHOW→LOAD_OP, LOAD_OP→LOAD_B, LOAD_B→LOAD_A. LOAD_A stays in LOAD_A. No register changes.
- CLEAR pulse: `portA`, `portB` and `op` ← 0; go to LOAD_A.
- Simultaneous pulses in one cycle: CLEAR wins over BACK, and BACK wins over LOAD. Only one action is taken.
- `valid` = (state == SHOW).
- Sign extension replicates `sw[SW_W-1]` into bits DATA_W-1..SW_W.
- Switch inputs are sampled directly at the capture edge, without synchronisers. Users set switches before pressing, so they are quasi-static.

## Timing
- Reset (`nRST` low at an edge):
  - `portA`, `portB`, `op` = 0; `valid` = 0; state = LOAD_A; `state_o` = 0.
  - All synchroniser flops and `stable` = 1; debounce counters = 0; pulses = 0.
  - Reset mid-debounce discards any partial count.
- Press latency: let the raw key first be sampled low at edge E0 and held low.
  - Synchronised level is low after E1.
  - `stable` falls at edge E1+DEBOUNCE_CYCLES.
  - Press pulse is high in the cycle after edge E2+DEBOUNCE_CYCLES.
  - Registers and state update at edge E3+DEBOUNCE_CYCLES.
- Glitch rejection: a low excursion shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse.
- One pulse per debounced press. Holding the key produces no repeats.
- Outputs change only at state-transition edges and are constant otherwise.

## Structure
- Package `alu_loader_pkg`:
  - `loader_state_t` enum (LOAD_A=2'd0, LOAD_B, LOAD_OP, SHOW).
  - Key index constants KEY_LOAD=0, KEY_CLEAR=1, KEY_BACK=2.
  - `OP_W`=4.
- Sub-module `key_debounce` (parameter DEBOUNCE_CYCLES; ports CLK, nRST, key_n, press): contains the synchroniser, counter, `stable` and pulse register. Instantiated three times.
- Top level contains the FSM and the operand registers only.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- **Reset:** drive `nRST` low for 2 edges with keys released → all outputs 0, `state_o`=0, `valid`=0.
- **Full load:**
  - `sw`=17'h1FFFF, LOAD → `portA`=32'hFFFFFFFF exactly 7 edges after the first low sample.
  - `sw`=17'h00005, LOAD → `portB`=32'h00000005.
  - `sw`=17'h00002, LOAD → `op`=4'h2, `valid`=1, `state_o`=3.
- **Bounce:** LOAD low 3 cycles, high 2, low 3, then released → no state change. A subsequent 6-cycle-held press → exactly one transition.
- **Priority:** in LOAD_B with `portA`=32'h5, CLEAR and LOAD pressed on the same edge → `portA`/`portB`/`op`=0, `state_o`=0.
- **Back:** in SHOW with A=1, B=2, op=3, BACK → `state_o`=2, `valid`=0, A/B/op unchanged. A further LOAD with `sw`=17'h7 → `op`=7, `valid`=1.
- **Mid-debounce reset:** LOAD held 2 cycles, `nRST` low 1 edge, LOAD held 2 more cycles then released → no pulse, state LOAD_A, `portA`=0.
